// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and region constants for the conv accelerator loader
//   Contents: state_t (3-bit loader FSM encoding), default word/region geometry,
//             cnt_w() helper giving a counter width of at least one bit.
package conv_pkg;

    localparam int             CONV_WORD_BYTES = 4;
    localparam int             CONV_ADDR_W     = 8;
    localparam logic [7:0]     CONV_FILT_BASE  = 8'h00;
    localparam int             CONV_FILT_WORDS = 4;
    localparam logic [7:0]     CONV_PIC_BASE   = 8'h10;
    localparam int             CONV_PIC_WORDS  = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_F    = 3'd1,
        ST_LOAD_P    = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word packer with registered word output
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : zero the byte counter and pack register
//   in_accept       : a byte is transferred this cycle
//   in_byte         : the byte being transferred
//   word_last       : combinational, the accepted byte completes a word
//   word_valid      : one-cycle pulse, the cycle after the completing byte
//   word_data       : packed word, held between pulses
module byte_packer
    import conv_pkg::*;
#(
    parameter int WORD_BYTES = CONV_WORD_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_accept,
    input  logic [7:0]              in_byte,
    output logic                    word_last,
    output logic                    word_valid,
    output logic [8*WORD_BYTES-1:0] word_data
);

    localparam int              BC_W     = cnt_w(WORD_BYTES);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(WORD_BYTES - 1);

    logic [BC_W-1:0]           cnt_q, cnt_d;
    logic [8*WORD_BYTES-1:0]   pack_q, pack_d;
    logic                      word_valid_q, word_valid_d;
    logic [8*WORD_BYTES-1:0]   word_data_q, word_data_d;

    always_comb begin
        cnt_d        = cnt_q;
        pack_d       = pack_q;
        word_valid_d = 1'b0;
        word_data_d  = word_data_q;
        word_last    = in_accept && (cnt_q == BC_LAST);
        if (clear) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (in_accept) begin
            pack_d[8*cnt_q +: 8] = in_byte;
            cnt_d = (cnt_q == BC_LAST) ? '0 : cnt_q + 1'b1;
            if (word_last) begin
                // Capture including the byte arriving now, so the write needs no extra cycle.
                word_valid_d = 1'b1;
                word_data_d  = pack_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            pack_q       <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            pack_q       <= pack_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;

endmodule

// File: rtl/conv_mem_loader.sv
// rtl/conv_mem_loader.sv - stream loader filling filter then picture memory, then running the accelerator
//   clk, rst                : clock, asynchronous active-high reset
//   load_req                : start a load/run sequence (IDLE only)
//   in_data/in_valid/in_ready : byte stream handshake
//   mem_we/mem_addr/mem_wdata : accelerator memory write port
//   acc_start/acc_done      : accelerator run handshake
//   busy                    : sequence in progress
//   loaded                  : one-cycle completion pulse
module conv_mem_loader
    import conv_pkg::*;
#(
    parameter int                WORD_BYTES = CONV_WORD_BYTES,
    parameter int                ADDR_W     = CONV_ADDR_W,
    parameter logic [ADDR_W-1:0] FILT_BASE  = ADDR_W'(CONV_FILT_BASE),
    parameter int                FILT_WORDS = CONV_FILT_WORDS,
    parameter logic [ADDR_W-1:0] PIC_BASE   = ADDR_W'(CONV_PIC_BASE),
    parameter int                PIC_WORDS  = CONV_PIC_WORDS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_req,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    acc_start,
    input  logic                    acc_done,
    output logic                    busy,
    output logic                    loaded
);

    localparam int FW_W   = cnt_w(FILT_WORDS);
    localparam int PW_W   = cnt_w(PIC_WORDS);
    // One index counter serves both regions, so it takes the wider of the two sizes.
    localparam int WIDX_W = (FW_W > PW_W) ? FW_W : PW_W;
    localparam logic [WIDX_W-1:0] FILT_LAST = WIDX_W'(FILT_WORDS - 1);
    localparam logic [WIDX_W-1:0] PIC_LAST  = WIDX_W'(PIC_WORDS - 1);

    state_t              state_q, state_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                acc_start_q, acc_start_d;
    logic                pk_clear;
    logic                pk_last;
    logic                accept;

    assign in_ready = (state_q == ST_LOAD_F) || (state_q == ST_LOAD_P);
    assign accept   = in_valid && in_ready;

    byte_packer #(
        .WORD_BYTES (WORD_BYTES)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .in_accept  (accept),
        .in_byte    (in_data),
        .word_last  (pk_last),
        .word_valid (mem_we),
        .word_data  (mem_wdata)
    );

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        mem_addr_d  = mem_addr_q;
        acc_start_d = 1'b0;
        pk_clear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    state_d  = ST_LOAD_F;
                    widx_d   = '0;
                    pk_clear = 1'b1;
                end
            end
            ST_LOAD_F: begin
                if (pk_last) begin
                    // Address is registered alongside the packed word so both land on the write cycle.
                    mem_addr_d = FILT_BASE + ADDR_W'(widx_q);
                    if (widx_q == FILT_LAST) begin
                        widx_d  = '0;
                        state_d = ST_LOAD_P;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            ST_LOAD_P: begin
                if (pk_last) begin
                    mem_addr_d = PIC_BASE + ADDR_W'(widx_q);
                    if (widx_q == PIC_LAST) begin
                        widx_d  = '0;
                        state_d = ST_START;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                // Final write goes out this cycle; start follows so memory is complete.
                state_d     = ST_WAIT_DONE;
                acc_start_d = 1'b1;
            end
            ST_WAIT_DONE: begin
                if (acc_done) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            widx_q      <= '0;
            mem_addr_q  <= '0;
            acc_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            mem_addr_q  <= mem_addr_d;
            acc_start_q <= acc_start_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign acc_start = acc_start_q;
    assign busy      = (state_q != ST_IDLE);
    assign loaded    = (state_q == ST_FINISH);

endmodule
